// File: rtl/multdiv_sequencer.sv
// Issues one mult/div request to the shared iterative multdiv unit, stalls the
// pipeline until the unit answers or a timeout expires, then returns the result in one done cycle.
module multdiv_sequencer #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        exception,
  output logic [31:0] rstatus,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       res_q, res_d;
  logic              exc_q, exc_d;
  logic [31:0]       rstatus_q, rstatus_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              mult_q, mult_d;
  logic              div_q, div_d;
  logic [31:0]       exc_status;

  // Cause code reported when the op faults or times out: 4 for mult, 5 for div.
  assign exc_status = op_q ? 32'd5 : 32'd4;

  always_comb begin
    // NOTE: every _d starts from its held value (pulses from 0) so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    res_d     = res_q;
    exc_d     = exc_q;
    rstatus_d = rstatus_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    mult_d    = 1'b0;
    div_d     = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            rd_d    = req_rd;
            mult_d  = ~req_op;
            div_d   = req_op;
            state_d = S_START;
          end
        end
        S_START: begin
          // Any ready seen here belongs to an earlier, abandoned op.
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (md_resultRDY) begin
            res_d     = md_result;
            exc_d     = md_exception;
            rstatus_d = md_exception ? exc_status : 32'd0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            res_d     = 32'd0;
            exc_d     = 1'b1;
            rstatus_d = exc_status;
            tmo_d     = 1'b1;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and clears the operand/result latches too, so every output reads 0.
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      rstatus_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      rstatus_q <= rstatus_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      mult_q    <= mult_d;
      div_q     <= div_d;
    end
  end

  assign stall        = (state_q == S_IDLE && req_valid) || state_q == S_START || state_q == S_WAIT;
  assign md_operandA  = a_q;
  assign md_operandB  = b_q;
  assign md_ctrl_MULT = mult_q;
  assign md_ctrl_DIV  = div_q;
  assign done         = done_q;
  assign timeout      = tmo_q;
  assign result       = res_q;
  assign result_rd    = rd_q;
  assign exception    = exc_q;
  assign rstatus      = rstatus_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: a behavioural multdiv unit answers start pulses,
// a reference model predicts each completion, and a monitor checks every done cycle.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 48;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        stall, done, exception, timeout;
  logic [31:0] result, rstatus;
  logic [4:0]  result_rd;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .done(done), .result(result), .result_rd(result_rd),
    .exception(exception), .rstatus(rstatus), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] rstat;
    logic        tmo;
    int          stall_cycles;
    logic        op;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   lat_cfg = 1;   // unit latency for the next started op; 0 = never ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: what the unit should compute, and how the sequencer should report it.
  function automatic logic [31:0] unit_value(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op) return a * b;
    if (b == 0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int lat);
    exp_t e;
    e.rd = rd;
    e.op = op;
    if (lat == 0 || lat > TIMEOUT) begin
      e.res = 32'd0; e.exc = 1'b1; e.tmo = 1'b1;
      e.rstat = op ? 32'd5 : 32'd4;
      e.stall_cycles = TIMEOUT + 2;
    end else begin
      e.res = unit_value(op, a, b);
      e.exc = op && (b == 0);
      e.tmo = 1'b0;
      e.rstat = e.exc ? 32'd5 : 32'd0;
      e.stall_cycles = lat + 2;
    end
    return e;
  endfunction

  // Behavioural multdiv unit: ready arrives lat_cfg cycles after the start cycle.
  int          u_left = 0;
  logic [31:0] u_a = '0, u_b = '0;
  logic        u_op = 1'b0;
  initial begin
    forever begin
      @(posedge clock); #1;
      md_resultRDY = 1'b0;
      if (!reset) u_left = 0;
      if (u_left == 1) begin
        md_resultRDY = 1'b1;
        md_result    = unit_value(u_op, u_a, u_b);
        md_exception = u_op && (u_b == 0);
        u_left = 0;
      end else if (u_left > 1) begin
        u_left--;
      end
      if (md_ctrl_MULT || md_ctrl_DIV) begin
        u_op = md_ctrl_DIV;
        u_a = md_operandA;
        u_b = md_operandB;
        u_left = lat_cfg;
      end
    end
  end

  // Monitor: compares each done cycle against the oldest expected completion.
  int   stall_cnt = 0, mult_cnt = 0, div_cnt = 0;
  exp_t cur;
  initial begin
    forever begin
      @(negedge clock);
      if (stall) stall_cnt++;
      if (md_ctrl_MULT) mult_cnt++;
      if (md_ctrl_DIV) div_cnt++;
      if (md_ctrl_MULT || md_ctrl_DIV)
        check("start_exclusive", 32'(md_ctrl_MULT & md_ctrl_DIV), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 result=0x%0h, expected no completion at %0t", result, $time);
        end else begin
          cur = sb.pop_front();
          check("result", result, cur.res);
          check("result_rd", 32'(result_rd), 32'(cur.rd));
          check("exception", 32'(exception), 32'(cur.exc));
          check("rstatus", rstatus, cur.rstat);
          check("timeout", 32'(timeout), 32'(cur.tmo));
          check("stall_cycles", 32'(stall_cnt), 32'(cur.stall_cycles));
          check("mult_pulses", 32'(mult_cnt), cur.op ? 32'd0 : 32'd1);
          check("div_pulses", 32'(div_cnt), cur.op ? 32'd1 : 32'd0);
          check("stall_in_done", 32'(stall), 32'd0);
        end
        stall_cnt = 0; mult_cnt = 0; div_cnt = 0;
      end
      if (flush || !reset) begin
        stall_cnt = 0; mult_cnt = 0; div_cnt = 0;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_result_rd"}, 32'(result_rd), 32'd0);
    check({tag, "_exception"}, 32'(exception), 32'd0);
    check({tag, "_rstatus"}, rstatus, 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_opA"}, md_operandA, 32'd0);
    check({tag, "_opB"}, md_operandB, 32'd0);
    check({tag, "_starts"}, 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!(md_ctrl_MULT || md_ctrl_DIV) && n < 100);
    check("start_seen", 32'(md_ctrl_MULT | md_ctrl_DIV), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!done && n < TIMEOUT + 20);
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Present a request, drop it once started (scrambling the inputs), optionally await done.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input bit expect_done);
    lat_cfg = lat;
    if (expect_done) sb.push_back(model(op, a, b, rd, lat));
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    wait_start();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
    if (expect_done) wait_done();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no end of test, expected completion before 500000 time units");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    issue(1'b0, 32'd6,   32'd7, 5'd3, 16, 1'b1);
    issue(1'b1, 32'd100, 32'd7, 5'd4, 32, 1'b1);
    issue(1'b1, 32'd5,   32'd0, 5'd5, 3,  1'b1);
    issue(1'b0, 32'd11,  32'd13, 5'd6, 0, 1'b1);            // never ready: timeout
    issue(1'b0, 32'd12,  32'd12, 5'd7, TIMEOUT, 1'b1);      // ready on the terminal count
    issue(1'b1, 32'd50,  32'd2, 5'd8, TIMEOUT + 1, 1'b1);   // one cycle too late

    // Flush at WAIT cycle 5; the stale ready lands in the next op's START cycle.
    lat_cfg = 7;
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd6; req_b = 32'd7; req_rd = 5'd10;
    wait_start();
    req_valid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_idle_stall", 32'(stall), 32'd0);
    issue(1'b0, 32'd3, 32'd3, 5'd11, 4, 1'b1);

    // Reset in the middle of WAIT.
    issue(1'b0, 32'd8, 32'd8, 5'd12, 0, 1'b0);
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check_zero("midreset");
    @(posedge clock); #1;
    reset = 1'b1;

    // Back-to-back with req_valid held: second op starts two cycles after the first done.
    begin
      int gap = 0;
      lat_cfg = 5;
      sb.push_back(model(1'b0, 32'd2, 32'd2, 5'd13, 5));
      req_valid = 1'b1; req_op = 1'b0; req_a = 32'd2; req_b = 32'd2; req_rd = 5'd13;
      wait_start();
      req_op = 1'b1; req_a = 32'd9; req_b = 32'd3; req_rd = 5'd14;
      lat_cfg = 6;
      sb.push_back(model(1'b1, 32'd9, 32'd3, 5'd14, 6));
      wait_done();
      do begin
        @(posedge clock); #1;
        gap++;
      end while (!(md_ctrl_MULT || md_ctrl_DIV) && gap < 10);
      check("b2b_gap", 32'(gap), 32'd2);
      req_valid = 1'b0;
      wait_done();
    end

    // Randomized ops, mixing short latencies with timeout boundaries and div-by-zero.
    for (int i = 0; i < 20; i++) begin
      logic        op;
      logic [31:0] a, b;
      int          r, lat;
      op = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      r = $urandom_range(0, 9);
      lat = (r < 7) ? $urandom_range(1, 12) : (r == 7) ? TIMEOUT : (r == 8) ? TIMEOUT - 1 : 0;
      issue(op, a, b, 5'($urandom), lat, 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    end

    repeat (5) @(posedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
